scoreboard: RTL and testbench
=============================

Name: scoreboard

Overview:
- Per-register in-flight tracker for the dual-issue pipeline.
- Records destination registers of instructions issued from slot0/slot1 and releases them on writeback.
- Drives busy_vec and load_pending_vec, which the issue unit consumes the following cycle.
- Sits between the issue decision (upstream, same cycle) and the writeback ports (downstream).

Parameters:
- CNT_W, 2, width of the per-register outstanding-writer counter; max count = 2^CNT_W-1.
- NREGS, 32, architectural register count; x0 is never tracked.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; discards all tracking state
- iss0_valid  in  1  slot0 issued this cycle
- iss0_we  in  1  slot0 writes a register
- iss0_load  in  1  slot0 is a load
- iss0_rd  in  5  slot0 destination
- iss1_valid  in  1  slot1 issued this cycle
- iss1_we  in  1  slot1 writes a register
- iss1_load  in  1  slot1 is a load
- iss1_rd  in  5  slot1 destination
- wb0_valid  in  1  writeback port 0 retires a write
- wb0_load  in  1  retiring write on port 0 was a load
- wb0_rd  in  5  writeback port 0 destination
- wb1_valid  in  1  writeback port 1 retires a write
- wb1_load  in  1  retiring write on port 1 was a load
- wb1_rd  in  5  writeback port 1 destination
- busy_vec  out  32  bit r = one or more outstanding writers of r
- load_pending_vec  out  32  bit r = one or more outstanding load writers of r
- inflight_cnt  out  6  total outstanding tracked writes, saturating at 63
- overflow_err  out  1  sticky: increment attempted at max count
- underflow_err  out  1  sticky: decrement attempted at zero

Behaviour:
- State: per register r (1..31), wcnt[r] and lcnt[r], each CNT_W bits. lcnt[r] <= wcnt[r] is maintained.
- Reset (async, rst=1): all counters 0; busy_vec=0, load_pending_vec=0, inflight_cnt=0, overflow_err=0, underflow_err=0.
- Outputs are pure functions of registered state:
  - busy_vec[r] = (wcnt[r]!=0).
  - load_pending_vec[r] = (lcnt[r]!=0).
  - Bit 0 of both vectors is always 0.
  - Latency: an issue or writeback at edge N is visible after edge N. There is no same-cycle bypass.
- An event on register r is counted only if valid && rd!=0. Issue events additionally require we=1.
- Per cycle, for each r:
  - inc = number of issue slots targeting r (0..2).
  - dec = number of writeback ports targeting r (0..2).
  - wcnt[r] += inc - dec.
  - lcnt[r] updates the same way, counting only events with the load flag set.
  - Simultaneous issue and writeback on the same r net out. Example: cnt 1, one issue and one wb leaves cnt 1.
- Overflow: if the net result would exceed the maximum, the counter saturates at the maximum and overflow_err sets.
- Underflow: if the net result would go below 0, the counter clamps at 0 and underflow_err sets.
- Both error flags are sticky until rst. flush does not clear them.
- A wb with load=1 whose lcnt is 0 decrements wcnt only and sets underflow_err.
- Both issue slots may target the same rd (+2). Both wb ports may target the same rd (-2).
- inflight_cnt = sum of wcnt[r], held in a register and updated by the same net delta. It saturates at 63 and floors at 0.
- flush=1: at the next edge all wcnt, lcnt and inflight_cnt clear to 0. Issue and wb inputs in the flush cycle are ignored.
- rst asserted mid-operation: all state clears immediately, independent of clk.

Test Plan:
- Reset then idle: after rst deassert, busy_vec=0, load_pending_vec=0, inflight_cnt=0, both error flags 0.
- Issue slot0 load rd=5 at edge 1, then wb0 rd=5 load=1 at edge 3 -> busy_vec=32'h20 and load_pending_vec=32'h20 after edges 1–2; both 0 after edge 3.
- Same-cycle dual issue: slot0 ALU rd=7 and slot1 ALU rd=7 -> wcnt[7]=2, inflight_cnt=2. Then a single wb rd=7 -> busy_vec[7] still 1, inflight_cnt=1.
- Simultaneous issue and wb on rd=3 with wcnt=1 -> busy_vec[3] stays 1, inflight_cnt unchanged. Issue or wb to rd=0 -> no state change.
- Saturation: four consecutive issues to rd=9 (CNT_W=2) -> wcnt=3, overflow_err=1. A wb to idle rd=4 -> underflow_err=1 and busy_vec[4] stays 0.
- Flush with issue rd=10 in the same cycle, prior busy on 1,2 -> all vectors 0 and inflight_cnt=0 after the edge; error flags retained.

Source files
------------

// File: rtl/scoreboard_if.sv
// Issue, writeback and status signals between the issue unit, writeback ports and the scoreboard.
// master = issue/writeback side, slave = scoreboard.
interface scoreboard_if;
    logic        flush;
    logic        iss0_valid;
    logic        iss0_we;
    logic        iss0_load;
    logic [4:0]  iss0_rd;
    logic        iss1_valid;
    logic        iss1_we;
    logic        iss1_load;
    logic [4:0]  iss1_rd;
    logic        wb0_valid;
    logic        wb0_load;
    logic [4:0]  wb0_rd;
    logic        wb1_valid;
    logic        wb1_load;
    logic [4:0]  wb1_rd;
    logic [31:0] busy_vec;
    logic [31:0] load_pending_vec;
    logic [5:0]  inflight_cnt;
    logic        overflow_err;
    logic        underflow_err;

    modport master (
        output flush,
        output iss0_valid, iss0_we, iss0_load, iss0_rd,
        output iss1_valid, iss1_we, iss1_load, iss1_rd,
        output wb0_valid, wb0_load, wb0_rd,
        output wb1_valid, wb1_load, wb1_rd,
        input  busy_vec, load_pending_vec, inflight_cnt, overflow_err, underflow_err
    );

    modport slave (
        input  flush,
        input  iss0_valid, iss0_we, iss0_load, iss0_rd,
        input  iss1_valid, iss1_we, iss1_load, iss1_rd,
        input  wb0_valid, wb0_load, wb0_rd,
        input  wb1_valid, wb1_load, wb1_rd,
        output busy_vec, load_pending_vec, inflight_cnt, overflow_err, underflow_err
    );
endinterface

// File: rtl/scoreboard.sv
// Per-register outstanding-writer tracker: issue increments, writeback decrements.
// Latency: events at edge N visible after edge N; no backpressure, inputs always accepted.
module scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREGS = 32
) (
    input  logic         clk,
    input  logic         rst,
    scoreboard_if.slave  sb
);
    localparam int MAXC = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] wcnt     [1:NREGS-1];
    logic [CNT_W-1:0] lcnt     [1:NREGS-1];
    logic [CNT_W-1:0] wcnt_nxt [1:NREGS-1];
    logic [CNT_W-1:0] lcnt_nxt [1:NREGS-1];
    logic [5:0]       inflight;
    logic [5:0]       inflight_nxt;
    logic             ovf_hit, unf_hit;
    logic             ovf_q, unf_q;
    logic             i0, i1, w0, w1;
    logic [31:0]      busy, lpend;

    assign i0 = sb.iss0_valid && sb.iss0_we && (sb.iss0_rd != 5'd0);
    assign i1 = sb.iss1_valid && sb.iss1_we && (sb.iss1_rd != 5'd0);
    assign w0 = sb.wb0_valid && (sb.wb0_rd != 5'd0);
    assign w1 = sb.wb1_valid && (sb.wb1_rd != 5'd0);

    always_comb begin : next_state
        int iw, il, dw, dl, nw, nl, delta, s;
        ovf_hit = 1'b0;
        unf_hit = 1'b0;
        delta   = 0;
        for (int r = 1; r < NREGS; r++) begin
            iw = int'(i0 && sb.iss0_rd == 5'(r)) + int'(i1 && sb.iss1_rd == 5'(r));
            il = int'(i0 && sb.iss0_load && sb.iss0_rd == 5'(r))
               + int'(i1 && sb.iss1_load && sb.iss1_rd == 5'(r));
            dw = int'(w0 && sb.wb0_rd == 5'(r)) + int'(w1 && sb.wb1_rd == 5'(r));
            dl = int'(w0 && sb.wb0_load && sb.wb0_rd == 5'(r))
               + int'(w1 && sb.wb1_load && sb.wb1_rd == 5'(r));
            nw = int'(wcnt[r]) + iw - dw;
            nl = int'(lcnt[r]) + il - dl;
            if (nw > MAXC) begin nw = MAXC; ovf_hit = 1'b1; end
            if (nw < 0)    begin nw = 0;    unf_hit = 1'b1; end
            if (nl > MAXC) begin nl = MAXC; ovf_hit = 1'b1; end
            if (nl < 0)    begin nl = 0;    unf_hit = 1'b1; end
            // A non-load retire can drain the last writer while a load count remains.
            if (nl > nw) nl = nw;
            wcnt_nxt[r] = CNT_W'(nw);
            lcnt_nxt[r] = CNT_W'(nl);
            delta = delta + nw - int'(wcnt[r]);
        end
        s = int'(inflight) + delta;
        if (s > 63) s = 63;
        if (s < 0)  s = 0;
        inflight_nxt = 6'(s);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NREGS; r++) begin
                wcnt[r] <= '0;
                lcnt[r] <= '0;
            end
            inflight <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (sb.flush) begin
            for (int r = 1; r < NREGS; r++) begin
                wcnt[r] <= '0;
                lcnt[r] <= '0;
            end
            inflight <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                wcnt[r] <= wcnt_nxt[r];
                lcnt[r] <= lcnt_nxt[r];
            end
            inflight <= inflight_nxt;
            ovf_q    <= ovf_q | ovf_hit;
            unf_q    <= unf_q | unf_hit;
        end
    end

    always_comb begin
        busy  = '0;
        lpend = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy[r]  = (wcnt[r] != '0);
            lpend[r] = (lcnt[r] != '0);
        end
    end

    assign sb.busy_vec         = busy;
    assign sb.load_pending_vec = lpend;
    assign sb.inflight_cnt     = inflight;
    assign sb.overflow_err     = ovf_q;
    assign sb.underflow_err    = unf_q;
endmodule

// File: tb/tb_scoreboard.sv
// Directed scenarios plus randomized traffic checked against an event-counting reference model.
module tb_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scoreboard_if sb();
    scoreboard #(.CNT_W(2), .NREGS(32)) dut (.clk(clk), .rst(rst), .sb(sb.slave));

    int checks = 0;
    int errors = 0;

    int mw[32];
    int ml[32];
    int minf;
    bit movf, munf;

    task automatic model_clear(bit errs);
        for (int r = 0; r < 32; r++) begin mw[r] = 0; ml[r] = 0; end
        minf = 0;
        if (errs) begin movf = 0; munf = 0; end
    endtask

    task automatic model_update();
        int dw[32];
        int dl[32];
        int nw, nl, total;
        if (sb.flush) begin model_clear(0); return; end
        for (int r = 0; r < 32; r++) begin dw[r] = 0; dl[r] = 0; end
        if (sb.iss0_valid && sb.iss0_we && sb.iss0_rd != 0) begin
            dw[sb.iss0_rd]++; if (sb.iss0_load) dl[sb.iss0_rd]++;
        end
        if (sb.iss1_valid && sb.iss1_we && sb.iss1_rd != 0) begin
            dw[sb.iss1_rd]++; if (sb.iss1_load) dl[sb.iss1_rd]++;
        end
        if (sb.wb0_valid && sb.wb0_rd != 0) begin
            dw[sb.wb0_rd]--; if (sb.wb0_load) dl[sb.wb0_rd]--;
        end
        if (sb.wb1_valid && sb.wb1_rd != 0) begin
            dw[sb.wb1_rd]--; if (sb.wb1_load) dl[sb.wb1_rd]--;
        end
        total = minf;
        for (int r = 1; r < 32; r++) begin
            nw = mw[r] + dw[r];
            nl = ml[r] + dl[r];
            if (nw > 3) begin nw = 3; movf = 1; end
            if (nw < 0) begin nw = 0; munf = 1; end
            if (nl > 3) begin nl = 3; movf = 1; end
            if (nl < 0) begin nl = 0; munf = 1; end
            if (nl > nw) nl = nw;
            total += nw - mw[r];
            mw[r] = nw;
            ml[r] = nl;
        end
        minf = (total > 63) ? 63 : (total < 0 ? 0 : total);
    endtask

    function automatic logic [31:0] exp_busy();
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) v[r] = (mw[r] != 0);
        return v;
    endfunction

    function automatic logic [31:0] exp_lp();
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) v[r] = (ml[r] != 0);
        return v;
    endfunction

    task automatic idle_in();
        sb.flush = 0;
        sb.iss0_valid = 0; sb.iss0_we = 0; sb.iss0_load = 0; sb.iss0_rd = 0;
        sb.iss1_valid = 0; sb.iss1_we = 0; sb.iss1_load = 0; sb.iss1_rd = 0;
        sb.wb0_valid = 0; sb.wb0_load = 0; sb.wb0_rd = 0;
        sb.wb1_valid = 0; sb.wb1_load = 0; sb.wb1_rd = 0;
    endtask

    task automatic set_iss(int slot, bit ld, int rd);
        if (slot == 0) begin
            sb.iss0_valid = 1; sb.iss0_we = 1; sb.iss0_load = ld; sb.iss0_rd = 5'(rd);
        end else begin
            sb.iss1_valid = 1; sb.iss1_we = 1; sb.iss1_load = ld; sb.iss1_rd = 5'(rd);
        end
    endtask

    task automatic set_wb(int port, bit ld, int rd);
        if (port == 0) begin
            sb.wb0_valid = 1; sb.wb0_load = ld; sb.wb0_rd = 5'(rd);
        end else begin
            sb.wb1_valid = 1; sb.wb1_load = ld; sb.wb1_rd = 5'(rd);
        end
    endtask

    // One clock edge with current inputs, then idle inputs; outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        idle_in();
    endtask

    task automatic test_reset();
        idle_in();
        rst = 1;
        model_clear(1);
        repeat (2) @(negedge clk);
        rst = 0;
        step();
        checks++; if (sb.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want 0", sb.busy_vec); end
        checks++; if (sb.load_pending_vec !== 32'h0) begin errors++; $display("FAIL reset_lp got %h want 0", sb.load_pending_vec); end
        checks++; if (sb.inflight_cnt !== 6'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", sb.inflight_cnt); end
        checks++; if (sb.overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", sb.overflow_err); end
        checks++; if (sb.underflow_err !== 1'b0) begin errors++; $display("FAIL reset_unf got %b want 0", sb.underflow_err); end
    endtask

    task automatic test_load();
        set_iss(0, 1, 5);
        step();
        checks++; if (sb.busy_vec !== 32'h20) begin errors++; $display("FAIL load_busy_e1 got %h want 20", sb.busy_vec); end
        checks++; if (sb.load_pending_vec !== 32'h20) begin errors++; $display("FAIL load_lp_e1 got %h want 20", sb.load_pending_vec); end
        step();
        checks++; if (sb.busy_vec !== 32'h20 || sb.load_pending_vec !== 32'h20) begin
            errors++; $display("FAIL load_e2 got busy %h lp %h want 20 20", sb.busy_vec, sb.load_pending_vec); end
        set_wb(0, 1, 5);
        step();
        checks++; if (sb.busy_vec !== 32'h0 || sb.load_pending_vec !== 32'h0) begin
            errors++; $display("FAIL load_wb got busy %h lp %h want 0 0", sb.busy_vec, sb.load_pending_vec); end
    endtask

    task automatic test_dual_issue();
        set_iss(0, 0, 7); set_iss(1, 0, 7);
        step();
        checks++; if (sb.busy_vec !== 32'h80 || sb.inflight_cnt !== 6'd2) begin
            errors++; $display("FAIL dual_iss got busy %h cnt %0d want 80 2", sb.busy_vec, sb.inflight_cnt); end
        checks++; if (sb.load_pending_vec !== 32'h0) begin errors++; $display("FAIL dual_iss_lp got %h want 0", sb.load_pending_vec); end
        set_wb(1, 0, 7);
        step();
        checks++; if (sb.busy_vec !== 32'h80 || sb.inflight_cnt !== 6'd1) begin
            errors++; $display("FAIL dual_wb1 got busy %h cnt %0d want 80 1", sb.busy_vec, sb.inflight_cnt); end
        set_wb(0, 0, 7);
        step();
        checks++; if (sb.busy_vec !== 32'h0 || sb.inflight_cnt !== 6'd0) begin
            errors++; $display("FAIL dual_wb2 got busy %h cnt %0d want 0 0", sb.busy_vec, sb.inflight_cnt); end
    endtask

    task automatic test_net_and_x0();
        set_iss(0, 0, 3);
        step();
        set_iss(1, 0, 3); set_wb(0, 0, 3);
        step();
        checks++; if (sb.busy_vec !== 32'h8 || sb.inflight_cnt !== 6'd1) begin
            errors++; $display("FAIL net_rd3 got busy %h cnt %0d want 8 1", sb.busy_vec, sb.inflight_cnt); end
        set_iss(0, 1, 0); set_wb(1, 1, 0);
        step();
        checks++; if (sb.busy_vec !== 32'h8 || sb.inflight_cnt !== 6'd1 || sb.underflow_err !== 1'b0) begin
            errors++; $display("FAIL x0 got busy %h cnt %0d unf %b want 8 1 0", sb.busy_vec, sb.inflight_cnt, sb.underflow_err); end
        set_wb(0, 0, 3);
        step();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            set_iss(i % 2, 0, 9);
            step();
        end
        checks++; if (sb.busy_vec !== 32'h200 || sb.inflight_cnt !== 6'd3) begin
            errors++; $display("FAIL sat got busy %h cnt %0d want 200 3", sb.busy_vec, sb.inflight_cnt); end
        checks++; if (sb.overflow_err !== 1'b1 || sb.underflow_err !== 1'b0) begin
            errors++; $display("FAIL sat_flags got ovf %b unf %b want 1 0", sb.overflow_err, sb.underflow_err); end
        set_wb(0, 0, 4);
        step();
        checks++; if (sb.underflow_err !== 1'b1 || sb.busy_vec[4] !== 1'b0 || sb.inflight_cnt !== 6'd3) begin
            errors++; $display("FAIL unf got unf %b busy4 %b cnt %0d want 1 0 3", sb.underflow_err, sb.busy_vec[4], sb.inflight_cnt); end
    endtask

    task automatic test_flush();
        set_iss(0, 0, 1); set_iss(1, 1, 2);
        step();
        checks++; if (sb.busy_vec !== 32'h206 || sb.load_pending_vec !== 32'h4) begin
            errors++; $display("FAIL pre_flush got busy %h lp %h want 206 4", sb.busy_vec, sb.load_pending_vec); end
        sb.flush = 1; set_iss(0, 1, 10);
        step();
        checks++; if (sb.busy_vec !== 32'h0 || sb.load_pending_vec !== 32'h0 || sb.inflight_cnt !== 6'd0) begin
            errors++; $display("FAIL flush got busy %h lp %h cnt %0d want 0 0 0", sb.busy_vec, sb.load_pending_vec, sb.inflight_cnt); end
        checks++; if (sb.overflow_err !== 1'b1 || sb.underflow_err !== 1'b1) begin
            errors++; $display("FAIL flush_flags got ovf %b unf %b want 1 1", sb.overflow_err, sb.underflow_err); end
    endtask

    task automatic test_async_reset();
        set_iss(0, 1, 6);
        step();
        @(posedge clk);
        #2 rst = 1;
        #1;
        checks++; if (sb.busy_vec !== 32'h0 || sb.inflight_cnt !== 6'd0 || sb.overflow_err !== 1'b0) begin
            errors++; $display("FAIL async_rst got busy %h cnt %0d ovf %b want 0 0 0", sb.busy_vec, sb.inflight_cnt, sb.overflow_err); end
        model_clear(1);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 1) set_iss(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) set_iss(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            sb.iss1_we = (sb.iss1_valid && $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) set_wb(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) != 0) set_wb(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            sb.flush = ($urandom_range(0, 39) == 0);
            step();
            checks++; if (sb.busy_vec !== exp_busy()) begin
                errors++; $display("FAIL rand_busy cyc %0d got %h want %h", n, sb.busy_vec, exp_busy()); end
            checks++; if (sb.load_pending_vec !== exp_lp()) begin
                errors++; $display("FAIL rand_lp cyc %0d got %h want %h", n, sb.load_pending_vec, exp_lp()); end
            checks++; if (int'(sb.inflight_cnt) != minf) begin
                errors++; $display("FAIL rand_inflight cyc %0d got %0d want %0d", n, sb.inflight_cnt, minf); end
            checks++; if (sb.overflow_err !== movf || sb.underflow_err !== munf) begin
                errors++; $display("FAIL rand_flags cyc %0d got %b%b want %b%b", n, sb.overflow_err, sb.underflow_err, movf, munf); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_dual_issue();
        test_net_and_x0();
        test_saturation();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
